// File: rtl/vga_draw_scheduler_pkg.sv
// Shared types and widths for the VGA draw scheduler slice.
package vga_draw_scheduler_pkg;

  localparam int unsigned X_W     = 8;
  localparam int unsigned Y_W     = 7;
  localparam int unsigned RGB_W   = 24;
  localparam int unsigned TADDR_W = 12;
  localparam int unsigned WDOG_W  = 20;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_CLR_START  = 3'd1,
    S_CLR_WAIT   = 3'd2,
    S_SCAN       = 3'd3,
    S_TILE_START = 3'd4,
    S_TILE_WAIT  = 3'd5
  } sched_state_e;

  typedef struct packed {
    logic               valid;
    logic [X_W-1:0]     x;
    logic [Y_W-1:0]     y;
    logic [TADDR_W-1:0] tile;
  } job_t;

  // Slot index width, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vga_draw_scheduler_vga_bus_mux.sv
// VGA bus selector: passes the clear or tile engine bus, otherwise drives zero.
module vga_bus_mux
  import vga_draw_scheduler_pkg::*;
(
  input  logic             sel_clr,
  input  logic             sel_tile,
  input  logic [X_W-1:0]   clr_x,
  input  logic [Y_W-1:0]   clr_y,
  input  logic [RGB_W-1:0] clr_rgb,
  input  logic             clr_plot,
  input  logic [X_W-1:0]   tile_vx,
  input  logic [Y_W-1:0]   tile_vy,
  input  logic [RGB_W-1:0] tile_rgb,
  input  logic             tile_plot,
  output logic [X_W-1:0]   vga_x,
  output logic [Y_W-1:0]   vga_y,
  output logic [RGB_W-1:0] vga_rgb,
  output logic             vga_plot
);

  // Select the owning engine's bus; idle bus is all zero with plot low
  always_comb begin
    vga_x    = '0;
    vga_y    = '0;
    vga_rgb  = '0;
    vga_plot = 1'b0;
    if (sel_clr) begin
      vga_x    = clr_x;
      vga_y    = clr_y;
      vga_rgb  = clr_rgb;
      vga_plot = clr_plot;
    end else if (sel_tile) begin
      vga_x    = tile_vx;
      vga_y    = tile_vy;
      vga_rgb  = tile_rgb;
      vga_plot = tile_plot;
    end
  end

endmodule

// File: rtl/vga_draw_scheduler.sv
// Per-frame sequencer owning the VGA write port: clear once, then draw each
// valid tile job from a snapshot of the job table taken at frame start.
// Optional statistics outputs (frame_cnt, ovr_cnt) when SCHED_STATS_EN is defined.
module vga_draw_scheduler
  import vga_draw_scheduler_pkg::*;
#(
  parameter  int unsigned       NUM_JOBS = 4,
  parameter  logic [WDOG_W-1:0] WDOG_CYC = 20'd65535,
  localparam int unsigned       IDX_W    = idx_width(NUM_JOBS)
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               frame_tick,
  input  logic               job_we,
  input  logic [IDX_W-1:0]   job_idx,
  input  logic               job_valid,
  input  logic [X_W-1:0]     job_x,
  input  logic [Y_W-1:0]     job_y,
  input  logic [TADDR_W-1:0] job_tile,
  output logic               clr_start,
  input  logic               clr_done,
  input  logic [X_W-1:0]     clr_x,
  input  logic [Y_W-1:0]     clr_y,
  input  logic [RGB_W-1:0]   clr_rgb,
  input  logic               clr_plot,
  output logic               tile_start,
  output logic [X_W-1:0]     tile_x,
  output logic [Y_W-1:0]     tile_y,
  output logic [TADDR_W-1:0] tile_addr,
  input  logic               tile_done,
  input  logic [X_W-1:0]     tile_vx,
  input  logic [Y_W-1:0]     tile_vy,
  input  logic [RGB_W-1:0]   tile_rgb,
  input  logic               tile_plot,
  output logic [X_W-1:0]     vga_x,
  output logic [Y_W-1:0]     vga_y,
  output logic [RGB_W-1:0]   vga_rgb,
  output logic               vga_plot,
  output logic               busy,
  output logic               overrun,
  output logic               wdog_err
`ifdef SCHED_STATS_EN
  ,
  output logic [15:0]        frame_cnt,
  output logic [7:0]         ovr_cnt
`endif
);

  localparam int unsigned       PTR_W     = IDX_W + 1;
  localparam logic [PTR_W-1:0]  PTR_END   = PTR_W'(NUM_JOBS);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_CYC - 20'd1;

  sched_state_e        state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [WDOG_W-1:0]   wdog_q, wdog_d;
  job_t                live_q [NUM_JOBS];
  job_t                live_d [NUM_JOBS];
  job_t                snap_q [NUM_JOBS];
  job_t                snap_d [NUM_JOBS];
  logic                clr_start_q, clr_start_d;
  logic                tile_start_q, tile_start_d;
  logic [X_W-1:0]      tile_x_q, tile_x_d;
  logic [Y_W-1:0]      tile_y_q, tile_y_d;
  logic [TADDR_W-1:0]  tile_addr_q, tile_addr_d;
  logic                busy_q, busy_d;
  logic                overrun_q, overrun_d;
  logic                wdog_err_q, wdog_err_d;
  logic                frame_done;
  logic                ovr_evt;
  logic [IDX_W-1:0]    pidx;

  assign pidx = ptr_q[IDX_W-1:0];

  // Next-state, job table, snapshot and registered-output computation
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    wdog_d      = wdog_q;
    live_d      = live_q;
    snap_d      = snap_q;
    tile_x_d    = tile_x_q;
    tile_y_d    = tile_y_q;
    tile_addr_d = tile_addr_q;
    overrun_d   = overrun_q;
    wdog_err_d  = wdog_err_q;
    frame_done  = 1'b0;
    ovr_evt     = 1'b0;

    if (job_we && (32'(job_idx) < NUM_JOBS)) begin
      live_d[job_idx].valid = job_valid;
      live_d[job_idx].x     = job_x;
      live_d[job_idx].y     = job_y;
      live_d[job_idx].tile  = job_tile;
    end

    case (state_q)
      S_IDLE: begin
        if (frame_tick) begin
          // Snapshot reads the registered table, so a coincident write lands next frame
          snap_d     = live_q;
          overrun_d  = 1'b0;
          wdog_err_d = 1'b0;
          ptr_d      = '0;
          state_d    = S_CLR_START;
        end
      end
      S_CLR_START: begin
        wdog_d  = '0;
        state_d = clr_done ? S_SCAN : S_CLR_WAIT;
      end
      S_CLR_WAIT: begin
        if (clr_done) begin
          state_d = S_SCAN;
        end else if (wdog_q == WDOG_LAST) begin
          wdog_err_d = 1'b1;
          state_d    = S_IDLE;
        end else begin
          wdog_d = wdog_q + 20'd1;
        end
      end
      S_SCAN: begin
        if (ptr_q >= PTR_END) begin
          frame_done = 1'b1;
          state_d    = S_IDLE;
        end else if (snap_q[pidx].valid) begin
          tile_x_d    = snap_q[pidx].x;
          tile_y_d    = snap_q[pidx].y;
          tile_addr_d = snap_q[pidx].tile;
          state_d     = S_TILE_START;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      S_TILE_START: begin
        wdog_d = '0;
        if (tile_done) begin
          ptr_d   = ptr_q + 1'b1;
          state_d = S_SCAN;
        end else begin
          state_d = S_TILE_WAIT;
        end
      end
      S_TILE_WAIT: begin
        if (tile_done) begin
          ptr_d   = ptr_q + 1'b1;
          state_d = S_SCAN;
        end else if (wdog_q == WDOG_LAST) begin
          wdog_err_d = 1'b1;
          state_d    = S_IDLE;
        end else begin
          wdog_d = wdog_q + 20'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (frame_tick && (state_q != S_IDLE)) begin
      overrun_d = 1'b1;
      ovr_evt   = 1'b1;
    end

    clr_start_d  = (state_d == S_CLR_START);
    tile_start_d = (state_d == S_TILE_START);
    busy_d       = (state_d != S_IDLE);
  end

  // FSM state, tables and registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      wdog_q       <= '0;
      live_q       <= '{default: '0};
      snap_q       <= '{default: '0};
      clr_start_q  <= 1'b0;
      tile_start_q <= 1'b0;
      tile_x_q     <= '0;
      tile_y_q     <= '0;
      tile_addr_q  <= '0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
      wdog_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      wdog_q       <= wdog_d;
      live_q       <= live_d;
      snap_q       <= snap_d;
      clr_start_q  <= clr_start_d;
      tile_start_q <= tile_start_d;
      tile_x_q     <= tile_x_d;
      tile_y_q     <= tile_y_d;
      tile_addr_q  <= tile_addr_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
      wdog_err_q   <= wdog_err_d;
    end
  end

  assign clr_start  = clr_start_q;
  assign tile_start = tile_start_q;
  assign tile_x     = tile_x_q;
  assign tile_y     = tile_y_q;
  assign tile_addr  = tile_addr_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;
  assign wdog_err   = wdog_err_q;

  vga_bus_mux u_mux (
    .sel_clr   (state_q == S_CLR_WAIT),
    .sel_tile  (state_q == S_TILE_WAIT),
    .clr_x     (clr_x),
    .clr_y     (clr_y),
    .clr_rgb   (clr_rgb),
    .clr_plot  (clr_plot),
    .tile_vx   (tile_vx),
    .tile_vy   (tile_vy),
    .tile_rgb  (tile_rgb),
    .tile_plot (tile_plot),
    .vga_x     (vga_x),
    .vga_y     (vga_y),
    .vga_rgb   (vga_rgb),
    .vga_plot  (vga_plot)
  );

`ifdef SCHED_STATS_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [7:0]  ovr_cnt_q, ovr_cnt_d;

  // Completed-frame counter wraps; overrun counter saturates
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    ovr_cnt_d   = ovr_cnt_q;
    if (frame_done) frame_cnt_d = frame_cnt_q + 16'd1;
    if (ovr_evt && (ovr_cnt_q != 8'hFF)) ovr_cnt_d = ovr_cnt_q + 8'd1;
  end

  // Statistics registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      frame_cnt_q <= '0;
      ovr_cnt_q   <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      ovr_cnt_q   <= ovr_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign ovr_cnt   = ovr_cnt_q;
`else
  logic unused_stats;
  assign unused_stats = frame_done ^ ovr_evt;
`endif

endmodule

// File: tb/tb_vga_draw_scheduler.sv
// Self-checking bench for vga_draw_scheduler.
module tb_vga_draw_scheduler;

  localparam int WDOG = 30000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        frame_tick, job_we, job_valid;
  logic [1:0]  job_idx;
  logic [7:0]  job_x;
  logic [6:0]  job_y;
  logic [11:0] job_tile;
  logic        clr_start, clr_done, clr_plot;
  logic [7:0]  clr_x;
  logic [6:0]  clr_y;
  logic [23:0] clr_rgb;
  logic        tile_start, tile_done, tile_plot;
  logic [7:0]  tile_x, tile_vx;
  logic [6:0]  tile_y, tile_vy;
  logic [11:0] tile_addr;
  logic [23:0] tile_rgb;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [23:0] vga_rgb;
  logic        vga_plot, busy, overrun, wdog_err;
`ifdef SCHED_STATS_EN
  logic [15:0] frame_cnt;
  logic [7:0]  ovr_cnt;
`endif

  vga_draw_scheduler #(.NUM_JOBS(4), .WDOG_CYC(20'(WDOG))) dut (
    .clk(clk), .resetn(resetn), .frame_tick(frame_tick),
    .job_we(job_we), .job_idx(job_idx), .job_valid(job_valid),
    .job_x(job_x), .job_y(job_y), .job_tile(job_tile),
    .clr_start(clr_start), .clr_done(clr_done),
    .clr_x(clr_x), .clr_y(clr_y), .clr_rgb(clr_rgb), .clr_plot(clr_plot),
    .tile_start(tile_start), .tile_x(tile_x), .tile_y(tile_y), .tile_addr(tile_addr),
    .tile_done(tile_done),
    .tile_vx(tile_vx), .tile_vy(tile_vy), .tile_rgb(tile_rgb), .tile_plot(tile_plot),
    .vga_x(vga_x), .vga_y(vga_y), .vga_rgb(vga_rgb), .vga_plot(vga_plot),
    .busy(busy), .overrun(overrun), .wdog_err(wdog_err)
`ifdef SCHED_STATS_EN
    , .frame_cnt(frame_cnt), .ovr_cnt(ovr_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Bench model of the live job table and the frame's expected tile order
  logic        m_valid [4];
  logic [7:0]  m_x [4];
  logic [6:0]  m_y [4];
  logic [11:0] m_t [4];
  logic [7:0]  e_x [4];
  logic [6:0]  e_y [4];
  logic [11:0] e_t [4];
  int          e_n;
  logic [7:0]  i_x [8];
  logic [6:0]  i_y [8];
  logic [11:0] i_t [8];
  int          n_iss;
  // Job written by the mid-frame / coincident-write injections
  int          w_idx;
  logic        w_valid;
  logic [7:0]  w_x;
  logic [6:0]  w_y;
  logic [11:0] w_t;

  typedef struct {
    logic [3:0]       valid;
    logic [3:0][7:0]  x;
    logic [3:0][6:0]  y;
    logic [3:0][11:0] t;
    int               clr_delay;
    int               tile_delay;
    int               exp_n;
  } frame_vec_t;

  frame_vec_t tv [4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_write(input int idx, input logic v, input logic [7:0] x,
                             input logic [6:0] y, input logic [11:0] t);
    m_valid[idx] = v; m_x[idx] = x; m_y[idx] = y; m_t[idx] = t;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) model_write(i, 1'b0, 8'h00, 7'h00, 12'h000);
  endtask

  task automatic write_job(input int idx, input logic v, input logic [7:0] x,
                           input logic [6:0] y, input logic [11:0] t);
    @(negedge clk);
    job_we = 1'b1; job_idx = 2'(idx); job_valid = v; job_x = x; job_y = y; job_tile = t;
    @(negedge clk);
    job_we = 1'b0;
    model_write(idx, v, x, y, t);
  endtask

  task automatic drive_w();
    job_we = 1'b1; job_idx = 2'(w_idx); job_valid = w_valid;
    job_x = w_x; job_y = w_y; job_tile = w_t;
  endtask

  // Expected tiles: valid slots of the table as it stands at frame start, in index order
  task automatic build_exp();
    e_n = 0;
    for (int i = 0; i < 4; i++) begin
      if (m_valid[i]) begin
        e_x[e_n] = m_x[i]; e_y[e_n] = m_y[i]; e_t[e_n] = m_t[i];
        e_n++;
      end
    end
  endtask

  task automatic compare_issues(input string tag);
    check({tag, "_ntiles"}, 64'(n_iss), 64'(e_n));
    for (int k = 0; k < e_n && k < n_iss; k++) begin
      check($sformatf("%s_x%0d", tag, k), 64'(i_x[k]), 64'(e_x[k]));
      check($sformatf("%s_y%0d", tag, k), 64'(i_y[k]), 64'(e_y[k]));
      check($sformatf("%s_addr%0d", tag, k), 64'(i_t[k]), 64'(e_t[k]));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    frame_tick = 1'b0; job_we = 1'b0; clr_done = 1'b0; tile_done = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    model_clear();
  endtask

  // mode: 0 plain, 1 tick during first tile wait, 2 job write during first tile wait,
  //       3 job write coincident with the frame tick, 4 300 ticks during the clear wait
  task automatic run_frame(input int clr_delay, input int tile_delay, input int mode);
    bit injected;
    int cyc;
    injected = 1'b0;
    cyc = 0;
    n_iss = 0;
    @(negedge clk);
    frame_tick = 1'b1;
    if (mode == 3) drive_w();
    @(negedge clk);
    frame_tick = 1'b0;
    job_we = 1'b0;
    if (mode == 3) model_write(w_idx, w_valid, w_x, w_y, w_t);
    check("clr_start_after_tick", 64'(clr_start), 64'(1));
    check("busy_after_tick", 64'(busy), 64'(1));
    check("overrun_clear_on_tick", 64'(overrun), 64'(0));
    check("wdog_err_clear_on_tick", 64'(wdog_err), 64'(0));
    clr_done = (clr_delay == 0);
    for (int i = 0; i < clr_delay; i++) begin
      @(negedge clk);
      if (i == 0) begin
        check("clr_start_one_cycle", 64'(clr_start), 64'(0));
        check("mux_clr_x", 64'(vga_x), 64'(8'h5A));
        check("mux_clr_rgb", 64'(vga_rgb), 64'(24'hABCDEF));
        check("mux_clr_plot", 64'(vga_plot), 64'(1));
      end
      if (mode == 4) frame_tick = (i < 600) && ((i % 2) == 0);
      if (i == clr_delay - 1) clr_done = 1'b1;
    end
    @(negedge clk);
    clr_done = 1'b0;
    while (busy && cyc < 3000) begin
      if (tile_start) begin
        if (n_iss < 8) begin
          i_x[n_iss] = tile_x; i_y[n_iss] = tile_y; i_t[n_iss] = tile_addr;
        end
        n_iss++;
        tile_done = (tile_delay == 0);
        for (int i = 0; i < tile_delay; i++) begin
          @(negedge clk);
          cyc++;
          if (i == 0) begin
            check("tile_start_one_cycle", 64'(tile_start), 64'(0));
            check("mux_tile_x", 64'(vga_x), 64'(8'hC3));
            check("mux_tile_y", 64'(vga_y), 64'(7'h2A));
            check("mux_tile_plot", 64'(vga_plot), 64'(1));
          end
          if (mode == 1 && !injected) begin
            if (i == 0) frame_tick = 1'b1;
            else if (i == 1) begin
              frame_tick = 1'b0;
              check("overrun_set", 64'(overrun), 64'(1));
              check("no_restart_clr_start", 64'(clr_start), 64'(0));
              injected = 1'b1;
            end
          end
          if (mode == 2 && !injected) begin
            if (i == 0) drive_w();
            else if (i == 1) begin
              job_we = 1'b0;
              model_write(w_idx, w_valid, w_x, w_y, w_t);
              injected = 1'b1;
            end
          end
          if (i == tile_delay - 1) begin
            check("tile_x_stable", 64'(tile_x), 64'(i_x[(n_iss - 1) % 8]));
            tile_done = 1'b1;
          end
        end
        @(negedge clk);
        cyc++;
        tile_done = 1'b0;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    check("frame_end_busy", 64'(busy), 64'(0));
    check("frame_end_vga_plot", 64'(vga_plot), 64'(0));
  endtask

  initial begin
    int c;
    int pulses;
    resetn = 1'b0;
    frame_tick = 1'b0; job_we = 1'b0; job_idx = 2'd0; job_valid = 1'b0;
    job_x = 8'h00; job_y = 7'h00; job_tile = 12'h000;
    clr_done = 1'b0; tile_done = 1'b0;
    clr_x = 8'h5A; clr_y = 7'h33; clr_rgb = 24'hABCDEF; clr_plot = 1'b1;
    tile_vx = 8'hC3; tile_vy = 7'h2A; tile_rgb = 24'h123456; tile_plot = 1'b1;
    model_clear();

    tv[0] = '{valid: 4'b0101,
              x: {8'd200, 8'd24, 8'd100, 8'd8}, y: {7'd100, 7'd0, 7'd50, 7'd16},
              t: {12'hFFF, 12'h080, 12'h111, 12'h040},
              clr_delay: 19200, tile_delay: 3, exp_n: 2};
    tv[1] = '{valid: 4'b0000,
              x: {8'd1, 8'd2, 8'd3, 8'd4}, y: {7'd1, 7'd2, 7'd3, 7'd4},
              t: {12'h001, 12'h002, 12'h003, 12'h004},
              clr_delay: 2, tile_delay: 1, exp_n: 0};
    tv[2] = '{valid: 4'b1111,
              x: {8'd96, 8'd64, 8'd32, 8'd0}, y: {7'd90, 7'd60, 7'd30, 7'd0},
              t: {12'h300, 12'h200, 12'h100, 12'h000},
              clr_delay: 0, tile_delay: 0, exp_n: 4};
    tv[3] = '{valid: 4'b1000,
              x: {8'd255, 8'd7, 8'd7, 8'd7}, y: {7'd127, 7'd7, 7'd7, 7'd7},
              t: {12'hFFF, 12'h007, 12'h007, 12'h007},
              clr_delay: 1, tile_delay: 2, exp_n: 1};

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_vga_plot", 64'(vga_plot), 64'(0));
    check("rst_clr_start", 64'(clr_start), 64'(0));
    check("rst_tile_start", 64'(tile_start), 64'(0));
    check("rst_tile_x", 64'(tile_x), 64'(0));
    resetn = 1'b1;

    // Idle for 100 cycles with no tick
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (clr_start || tile_start || busy) pulses++;
    end
    check("idle_no_activity", 64'(pulses), 64'(0));
    check("idle_vga_plot", 64'(vga_plot), 64'(0));
    check("idle_overrun", 64'(overrun), 64'(0));
    check("idle_wdog_err", 64'(wdog_err), 64'(0));

    // Table-driven frames
    for (int v = 0; v < 4; v++) begin
      for (int s = 0; s < 4; s++)
        write_job(s, tv[v].valid[s], tv[v].x[s], tv[v].y[s], tv[v].t[s]);
      build_exp();
      run_frame(tv[v].clr_delay, tv[v].tile_delay, 0);
      check($sformatf("vec%0d_count", v), 64'(n_iss), 64'(tv[v].exp_n));
      compare_issues($sformatf("vec%0d", v));
      check($sformatf("vec%0d_overrun", v), 64'(overrun), 64'(0));
    end

    // Tick while drawing: ignored, overrun sticky until next accepted tick
    write_job(0, 1'b1, 8'd8, 7'd16, 12'h040);
    build_exp();
    run_frame(2, 3, 1);
    compare_issues("ovr_frame");
    check("overrun_sticky", 64'(overrun), 64'(1));
    build_exp();
    run_frame(1, 2, 0);
    compare_issues("post_ovr_frame");
    check("overrun_after_clean_frame", 64'(overrun), 64'(0));

    // Mid-frame write of slot0 applies only to the next frame
    w_idx = 0; w_valid = 1'b1; w_x = 8'd40; w_y = 7'd40; w_t = 12'h100;
    build_exp();
    run_frame(1, 3, 2);
    compare_issues("midwrite_cur");
    build_exp();
    run_frame(1, 1, 0);
    compare_issues("midwrite_next");

    // Write coincident with accepted tick: snapshot keeps the old slot3
    w_idx = 3; w_valid = 1'b0; w_x = 8'd0; w_y = 7'd0; w_t = 12'h000;
    build_exp();
    run_frame(1, 1, 3);
    compare_issues("coinc_cur");
    build_exp();
    run_frame(1, 1, 0);
    compare_issues("coinc_next");

    // Watchdog: clr_done never arrives
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    c = 1;
    while (!wdog_err && c < WDOG + 50) begin
      if (c == WDOG - 5) check("wdog_not_early", 64'(busy), 64'(1));
      @(negedge clk);
      c++;
    end
    check("wdog_err_set", 64'(wdog_err), 64'(1));
    check("wdog_latency_lo", 64'(c >= WDOG + 1), 64'(1));
    check("wdog_latency_hi", 64'(c <= WDOG + 3), 64'(1));
    check("wdog_idle_busy", 64'(busy), 64'(0));
    check("wdog_idle_plot", 64'(vga_plot), 64'(0));
    repeat (3) @(negedge clk);
    check("wdog_err_sticky", 64'(wdog_err), 64'(1));
    build_exp();
    run_frame(1, 1, 0);
    compare_issues("post_wdog");

    // Async reset during CLR_START drops the strobe immediately
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    check("pre_rst_clr_start", 64'(clr_start), 64'(1));
    #2 resetn = 1'b0;
    #1;
    check("rst_clr_start_drop", 64'(clr_start), 64'(0));
    check("rst_clr_busy_drop", 64'(busy), 64'(0));
    @(negedge clk);
    resetn = 1'b1;
    model_clear();

    // Async reset during TILE_WAIT returns to IDLE and drops vga_plot
    write_job(1, 1'b1, 8'd50, 7'd60, 12'h0AB);
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    clr_done = 1'b1;
    @(negedge clk);
    clr_done = 1'b0;
    c = 0;
    while (!tile_start && c < 50) begin
      @(negedge clk);
      c++;
    end
    check("rst_tile_reached", 64'(tile_start), 64'(1));
    @(negedge clk);
    check("rst_tile_wait_plot", 64'(vga_plot), 64'(1));
    #2 resetn = 1'b0;
    #1;
    check("rst_tile_plot_drop", 64'(vga_plot), 64'(0));
    check("rst_tile_busy_drop", 64'(busy), 64'(0));
    check("rst_tile_x_clear", 64'(tile_x), 64'(0));
    @(negedge clk);
    resetn = 1'b1;
    model_clear();
    build_exp();
    run_frame(1, 1, 0);
    compare_issues("post_rst_table");

`ifdef SCHED_STATS_EN
    do_reset();
    check("stats_rst_frame", 64'(frame_cnt), 64'(0));
    check("stats_rst_ovr", 64'(ovr_cnt), 64'(0));
    write_job(0, 1'b1, 8'd8, 7'd16, 12'h040);
    run_frame(1, 1, 0);
    run_frame(1, 3, 1);
    run_frame(1, 3, 1);
    check("stats_frame_cnt_3", 64'(frame_cnt), 64'(3));
    check("stats_ovr_cnt_2", 64'(ovr_cnt), 64'(2));
    run_frame(620, 1, 4);
    check("stats_ovr_sat", 64'(ovr_cnt), 64'(255));
    check("stats_frame_cnt_4", 64'(frame_cnt), 64'(4));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
